// File: rtl/blast_map_writer.sv
// Detonation walker: flames the bomb tile, then walks four arms (up, down, left, right)
// over the tile map, emitting flame strobes and clearing destructible blocks.
module blast_map_writer #(
   parameter int NUM_ROW       = 11,
   parameter int NUM_COL       = 19,
   parameter int MAP_MEM_WIDTH = 2,
   parameter int ADDR_WIDTH    = $clog2(NUM_ROW*NUM_COL)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     det_valid,
   output logic                     det_ready,
   input  logic [3:0]               det_row,
   input  logic [4:0]               det_col,
   input  logic [1:0]               det_range,
   output logic [ADDR_WIDTH-1:0]    rd_addr,
   input  logic [MAP_MEM_WIDTH-1:0] rd_data,
   output logic                     we_out,
   output logic [ADDR_WIDTH-1:0]    write_addr_out,
   output logic [MAP_MEM_WIDTH-1:0] write_data_out,
   output logic                     blast_valid,
   output logic [ADDR_WIDTH-1:0]    blast_addr,
   output logic                     busy,
   output logic                     done
);
   // Request handshake: a detonation is accepted on a clock edge where det_valid && det_ready;
   // det_ready is high only in IDLE, so requests arriving while busy are dropped, not queued.
   typedef enum logic [2:0] {S_IDLE, S_CENTER, S_READ, S_EVAL, S_NEXT_DIR, S_DONE} state_t;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   localparam logic [MAP_MEM_WIDTH-1:0] TILE_FREE  = MAP_MEM_WIDTH'(0);
   localparam logic [MAP_MEM_WIDTH-1:0] TILE_WALL  = MAP_MEM_WIDTH'(1);
   localparam logic [MAP_MEM_WIDTH-1:0] TILE_BLOCK = MAP_MEM_WIDTH'(2);

   state_t                  state_q;
   dir_t                    dir_q;
   logic [2:0]              step_q;
   logic [1:0]              range_q;
   logic [3:0]              ctr_row_q;
   logic [4:0]              ctr_col_q;
   logic [ADDR_WIDTH-1:0]   ctr_addr_q;
   logic [3:0]              row_q;
   logic [4:0]              col_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   rd_last_q;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic                    blast_q;
   logic [ADDR_WIDTH-1:0]   blast_addr_q;
   logic                    done_q;

   logic                    off_map;
   logic [3:0]              step_row_d;
   logic [4:0]              step_col_d;
   logic [ADDR_WIDTH-1:0]   step_addr_d;
   logic [ADDR_WIDTH-1:0]   center_addr;
   logic                    rd_issue;

   // Next tile along the current arm, tracked incrementally from the last tile examined.
   always_comb begin
      off_map     = 1'b0;
      step_row_d  = row_q;
      step_col_d  = col_q;
      step_addr_d = addr_q;
      case (dir_q)
         DIR_UP: begin
            off_map     = (row_q == 4'd0);
            step_row_d  = row_q - 4'd1;
            step_addr_d = addr_q - ADDR_WIDTH'(NUM_COL);
         end
         DIR_DOWN: begin
            off_map     = (row_q == 4'(NUM_ROW-1));
            step_row_d  = row_q + 4'd1;
            step_addr_d = addr_q + ADDR_WIDTH'(NUM_COL);
         end
         DIR_LEFT: begin
            off_map     = (col_q == 5'd0);
            step_col_d  = col_q - 5'd1;
            step_addr_d = addr_q - ADDR_WIDTH'(1);
         end
         default: begin
            off_map     = (col_q == 5'(NUM_COL-1));
            step_col_d  = col_q + 5'd1;
            step_addr_d = addr_q + ADDR_WIDTH'(1);
         end
      endcase
   end

   assign center_addr = ADDR_WIDTH'(det_row) * ADDR_WIDTH'(NUM_COL) + ADDR_WIDTH'(det_col);
   // The read address is live only in a READ cycle that stays on the map; otherwise it holds.
   assign rd_issue    = (state_q == S_READ) && !off_map;
   assign rd_addr     = rd_issue ? step_addr_d : rd_last_q;

   assign det_ready      = (state_q == S_IDLE);
   assign busy           = (state_q != S_IDLE);
   assign we_out         = we_q;
   assign write_addr_out = wr_addr_q;
   assign write_data_out = TILE_FREE;
   assign blast_valid    = blast_q;
   assign blast_addr     = blast_addr_q;
   assign done           = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         dir_q        <= DIR_UP;
         step_q       <= 3'd0;
         range_q      <= 2'd0;
         ctr_row_q    <= 4'd0;
         ctr_col_q    <= 5'd0;
         ctr_addr_q   <= '0;
         row_q        <= 4'd0;
         col_q        <= 5'd0;
         addr_q       <= '0;
         rd_last_q    <= '0;
         we_q         <= 1'b0;
         wr_addr_q    <= '0;
         blast_q      <= 1'b0;
         blast_addr_q <= '0;
         done_q       <= 1'b0;
      end else begin
         we_q    <= 1'b0;
         blast_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (det_valid) begin
                  range_q    <= det_range;
                  ctr_row_q  <= det_row;
                  ctr_col_q  <= det_col;
                  ctr_addr_q <= center_addr;
                  state_q    <= S_CENTER;
               end
            end
            S_CENTER: begin
               we_q         <= 1'b1;
               wr_addr_q    <= ctr_addr_q;
               blast_q      <= 1'b1;
               blast_addr_q <= ctr_addr_q;
               dir_q        <= DIR_UP;
               step_q       <= 3'd1;
               row_q        <= ctr_row_q;
               col_q        <= ctr_col_q;
               addr_q       <= ctr_addr_q;
               state_q      <= S_READ;
            end
            S_READ: begin
               if (off_map) begin
                  state_q <= S_NEXT_DIR;
               end else begin
                  row_q     <= step_row_d;
                  col_q     <= step_col_d;
                  addr_q    <= step_addr_d;
                  rd_last_q <= step_addr_d;
                  state_q   <= S_EVAL;
               end
            end
            S_EVAL: begin
               state_q <= S_NEXT_DIR;
               case (rd_data)
                  TILE_FREE: begin
                     blast_q      <= 1'b1;
                     blast_addr_q <= addr_q;
                     // step < range+1, i.e. the arm still has length left
                     if (step_q <= {1'b0, range_q}) begin
                        step_q  <= step_q + 3'd1;
                        state_q <= S_READ;
                     end
                  end
                  TILE_WALL: begin
                  end
                  TILE_BLOCK: begin
                     blast_q      <= 1'b1;
                     blast_addr_q <= addr_q;
                     we_q         <= 1'b1;
                     wr_addr_q    <= addr_q;
                  end
                  default: begin
                     blast_q      <= 1'b1;
                     blast_addr_q <= addr_q;
                  end
               endcase
            end
            S_NEXT_DIR: begin
               if (dir_q == DIR_RIGHT) begin
                  // done is raised here so the pulse is visible during the DONE cycle
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  dir_q   <= dir_t'(dir_q + 2'd1);
                  step_q  <= 3'd1;
                  row_q   <= ctr_row_q;
                  col_q   <= ctr_col_q;
                  addr_q  <= ctr_addr_q;
                  state_q <= S_READ;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blast_map_writer.sv
// Bench for blast_map_writer: directed scenarios plus randomized detonations checked
// against an arithmetic model of the blast pattern over a bench-held tile map.
module tb_blast_map_writer;
   localparam int NR = 11;
   localparam int NC = 19;
   localparam int AW = 8;
   localparam int MW = 2;

   logic          clk;
   logic          rst_n;
   logic          det_valid;
   logic          det_ready;
   logic [3:0]    det_row;
   logic [4:0]    det_col;
   logic [1:0]    det_range;
   logic [AW-1:0] rd_addr;
   logic [MW-1:0] rd_data;
   logic          we_out;
   logic [AW-1:0] write_addr_out;
   logic [MW-1:0] write_data_out;
   logic          blast_valid;
   logic [AW-1:0] blast_addr;
   logic          busy;
   logic          done;

   bit            clk_en;
   int            checks;
   int            errors;
   int            cyc;
   logic [MW-1:0] map_mem [NR*NC];
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] act_q[$];
   string         exp_wr_s;
   string         act_wr_s;
   bit            exp_rd [256];
   bit            act_rd [256];
   int            done_cnt;
   int            done_cyc;
   int            last_blast_cyc;
   int            hold_viol;
   logic [AW-1:0] prev_blast_addr;
   logic [AW-1:0] prev_wr_addr;
   logic [AW-1:0] rd_pre;

   blast_map_writer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .det_valid      (det_valid),
      .det_ready      (det_ready),
      .det_row        (det_row),
      .det_col        (det_col),
      .det_range      (det_range),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .we_out         (we_out),
      .write_addr_out (write_addr_out),
      .write_data_out (write_data_out),
      .blast_valid    (blast_valid),
      .blast_addr     (blast_addr),
      .busy           (busy),
      .done           (done)
   );

   // clock / reset / memory model
   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_data <= map_mem[rd_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, required finished", $time);
      $fatal(1, "watchdog");
   end

   // monitor: records strobes, reads and done pulses
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_blast_addr = blast_addr;
         prev_wr_addr    = write_addr_out;
      end else begin
         if (blast_valid) begin
            act_q.push_back(blast_addr);
            last_blast_cyc = cyc;
         end else if (blast_addr !== prev_blast_addr) hold_viol++;
         if (we_out) act_wr_s = {act_wr_s, $sformatf(" %0d:%0d", write_addr_out, write_data_out)};
         else if (write_addr_out !== prev_wr_addr) hold_viol++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         act_rd[rd_addr] = 1'b1;
         prev_blast_addr = blast_addr;
         prev_wr_addr    = write_addr_out;
      end
   end

   // reference model: walks each arm with plain row/column arithmetic
   task automatic model_det(input int r, input int c, input int rng);
      int dr [4] = '{-1, 1, 0, 0};
      int dc [4] = '{0, 0, -1, 1};
      int nr;
      int nc;
      int a;
      exp_q.delete();
      foreach (exp_rd[i]) exp_rd[i] = 1'b0;
      exp_q.push_back(AW'(r*NC + c));
      exp_wr_s = $sformatf(" %0d:0", r*NC + c);
      for (int d = 0; d < 4; d++) begin
         for (int s = 1; s <= rng + 1; s++) begin
            nr = r + dr[d]*s;
            nc = c + dc[d]*s;
            if (nr < 0 || nr >= NR || nc < 0 || nc >= NC) break;
            a = nr*NC + nc;
            exp_rd[a] = 1'b1;
            if (map_mem[a] == 2'd1) break;
            exp_q.push_back(AW'(a));
            if (map_mem[a] == 2'd2) begin
               exp_wr_s = {exp_wr_s, $sformatf(" %0d:0", a)};
               break;
            end
            if (map_mem[a] == 2'd3) break;
         end
      end
   endtask

   function automatic string list_str(input bit use_act);
      string s = "";
      if (use_act) foreach (act_q[i]) s = {s, $sformatf(" %0d", act_q[i])};
      else foreach (exp_q[i]) s = {s, $sformatf(" %0d", exp_q[i])};
      return s;
   endfunction

   function automatic int count_unexp_reads();
      int n = 0;
      for (int a = 0; a < 256; a++)
         if (act_rd[a] && !exp_rd[a] && a != int'(rd_pre)) n++;
      return n;
   endfunction

   task automatic fill_map(input int code);
      foreach (map_mem[i]) map_mem[i] = MW'(code);
   endtask

   // driver tasks
   task automatic clear_capture();
      act_q.delete();
      act_wr_s  = "";
      foreach (act_rd[i]) act_rd[i] = 1'b0;
      done_cnt  = 0;
      hold_viol = 0;
      rd_pre    = rd_addr;
   endtask

   task automatic start_det(input int r, input int c, input int rng);
      bit acc = 1'b0;
      @(negedge clk);
      #1;
      clear_capture();
      det_valid = 1'b1;
      det_row   = 4'(r);
      det_col   = 5'(c);
      det_range = 2'(rng);
      for (int i = 0; i < 20 && !acc; i++) begin
         @(posedge clk);
         if (det_ready) acc = 1'b1;
      end
      #1 det_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept: det_ready=%0b, required 1", det_ready);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt == 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", n);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      det_valid = 1'b0;
      det_row   = 4'd0;
      det_col   = 5'd0;
      det_range = 2'd0;
      fill_map(0);
      #1 rst_n = 1'b0;
      #4;
      checks += 9;
      if (det_ready !== 1'b1) begin errors++; $display("FAIL rst_det_ready: got %b, required 1", det_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
      if (we_out !== 1'b0) begin errors++; $display("FAIL rst_we: got %b, required 0", we_out); end
      if (blast_valid !== 1'b0) begin errors++; $display("FAIL rst_blast_valid: got %b, required 0", blast_valid); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
      if (rd_addr !== 8'd0) begin errors++; $display("FAIL rst_rd_addr: got %0d, required 0", rd_addr); end
      if (write_addr_out !== 8'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d, required 0", write_addr_out); end
      if (write_data_out !== 2'd0) begin errors++; $display("FAIL rst_wr_data: got %0d, required 0", write_data_out); end
      if (blast_addr !== 8'd0) begin errors++; $display("FAIL rst_blast_addr: got %0d, required 0", blast_addr); end
      clk_en = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks += 2;
      if (det_ready !== 1'b1) begin errors++; $display("FAIL rel_det_ready: got %b, required 1", det_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy: got %b, required 0", busy); end
   endtask

   task automatic test_open_field();
      fill_map(0);
      model_det(1, 1, 0);
      start_det(1, 1, 0);
      wait_done();
      checks += 5;
      if (list_str(1) != " 20 1 39 19 21") begin errors++; $display("FAIL open_blast: got%s, required 20 1 39 19 21", list_str(1)); end
      if (list_str(1) != list_str(0)) begin errors++; $display("FAIL open_blast_model: got%s, required%s", list_str(1), list_str(0)); end
      if (act_wr_s != " 20:0") begin errors++; $display("FAIL open_writes: got%s, required 20:0", act_wr_s); end
      if (done_cyc - last_blast_cyc != 1) begin errors++; $display("FAIL open_done_gap: got %0d, required 1", done_cyc - last_blast_cyc); end
      if (done_cnt != 1) begin errors++; $display("FAIL open_done_cnt: got %0d, required 1", done_cnt); end
   endtask

   task automatic test_destructible();
      fill_map(0);
      map_mem[21] = 2'd2;
      model_det(1, 1, 2);
      start_det(1, 1, 2);
      wait_done();
      checks += 3;
      if (list_str(1) != list_str(0)) begin errors++; $display("FAIL destr_blast: got%s, required%s", list_str(1), list_str(0)); end
      if (act_wr_s != " 20:0 21:0") begin errors++; $display("FAIL destr_writes: got%s, required 20:0 21:0", act_wr_s); end
      if (act_rd[22]) begin errors++; $display("FAIL destr_read22: read seen=1, required 0"); end
   endtask

   task automatic test_hard_wall();
      fill_map(0);
      map_mem[39] = 2'd1;
      model_det(1, 1, 1);
      start_det(1, 1, 1);
      wait_done();
      checks += 3;
      if (list_str(1) != list_str(0)) begin errors++; $display("FAIL wall_blast: got%s, required%s", list_str(1), list_str(0)); end
      if (act_wr_s != " 20:0") begin errors++; $display("FAIL wall_writes: got%s, required 20:0", act_wr_s); end
      if (act_rd[58]) begin errors++; $display("FAIL wall_read58: read seen=1, required 0"); end
   endtask

   task automatic test_edge();
      fill_map(0);
      model_det(0, 0, 3);
      start_det(0, 0, 3);
      wait_done();
      checks += 4;
      if (list_str(1) != " 0 19 38 57 76 1 2 3 4") begin errors++; $display("FAIL edge_blast: got%s, required 0 19 38 57 76 1 2 3 4", list_str(1)); end
      if (act_rd[18] || act_rd[208]) begin errors++; $display("FAIL edge_wrap_read: rd18=%0b rd208=%0b, required 0 0", act_rd[18], act_rd[208]); end
      if (count_unexp_reads() != 0) begin errors++; $display("FAIL edge_reads: %0d unexpected read addresses, required 0", count_unexp_reads()); end
      if (act_wr_s != " 0:0") begin errors++; $display("FAIL edge_writes: got%s, required 0:0", act_wr_s); end
   endtask

   task automatic test_random();
      int r;
      int c;
      int rng;
      int t;
      for (int it = 0; it < 20; it++) begin
         foreach (map_mem[i]) begin
            t = int'($urandom_range(0, 9));
            map_mem[i] = (t < 6) ? 2'd0 : MW'(t - 6);
         end
         r   = int'($urandom_range(0, NR-1));
         c   = int'($urandom_range(0, NC-1));
         rng = int'($urandom_range(0, 3));
         model_det(r, c, rng);
         start_det(r, c, rng);
         wait_done();
         checks += 5;
         if (list_str(1) != list_str(0)) begin errors++; $display("FAIL rand%0d_blast: got%s, required%s", it, list_str(1), list_str(0)); end
         if (act_wr_s != exp_wr_s) begin errors++; $display("FAIL rand%0d_writes: got%s, required%s", it, act_wr_s, exp_wr_s); end
         if (count_unexp_reads() != 0) begin errors++; $display("FAIL rand%0d_reads: %0d unexpected read addresses, required 0", it, count_unexp_reads()); end
         if (hold_viol != 0) begin errors++; $display("FAIL rand%0d_hold: %0d address changes without strobe, required 0", it, hold_viol); end
         if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done_cnt: got %0d, required 1", it, done_cnt); end
      end
   endtask

   task automatic test_busy();
      fill_map(0);
      model_det(3, 4, 2);
      start_det(3, 4, 2);
      repeat (4) @(negedge clk);
      #1;
      det_valid = 1'b1;
      det_row   = 4'd7;
      det_col   = 5'd10;
      det_range = 2'd1;
      checks += 2;
      if (det_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b, required 0", det_ready); end
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag: got %b, required 1", busy); end
      repeat (2) @(negedge clk);
      #1 det_valid = 1'b0;
      wait_done();
      repeat (30) @(negedge clk);
      checks += 2;
      if (done_cnt != 1) begin errors++; $display("FAIL busy_done_cnt: got %0d, required 1", done_cnt); end
      if (list_str(1) != list_str(0)) begin errors++; $display("FAIL busy_blast: got%s, required%s", list_str(1), list_str(0)); end
   endtask

   task automatic test_reset_mid();
      int n_blast;
      string wr_at_rst;
      fill_map(0);
      start_det(5, 9, 3);
      repeat (6) @(negedge clk);
      #2;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b, required 1", busy); end
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (we_out !== 1'b0) begin errors++; $display("FAIL mid_we: got %b, required 0", we_out); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
      if (blast_valid !== 1'b0) begin errors++; $display("FAIL mid_blast_valid: got %b, required 0", blast_valid); end
      if (det_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, required 1", det_ready); end
      n_blast   = act_q.size();
      wr_at_rst = act_wr_s;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      checks += 4;
      if (done_cnt != 0) begin errors++; $display("FAIL mid_done: got %0d pulses, required 0", done_cnt); end
      if (act_wr_s != wr_at_rst) begin errors++; $display("FAIL mid_writes: got%s, required%s", act_wr_s, wr_at_rst); end
      if (act_q.size() != n_blast) begin errors++; $display("FAIL mid_blasts: got %0d strobes, required %0d", act_q.size(), n_blast); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: busy=%b, required 0", busy); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      clk_en = 1'b0;
      test_reset();
      test_open_field();
      test_destructible();
      test_hard_wall();
      test_edge();
      test_busy();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
